// File: rtl/vram_bus_pkg.sv
// Shared widths, source-ID encoding and read-tag layout for the VRAM bus arbiter.
// Source 0 is the host; client i is carried as i+1.
package vram_bus_pkg;
  localparam int VRAM_AW = 19;
  localparam int VRAM_DW = 8;
  localparam int SRC_W   = 4;
  localparam logic [SRC_W-1:0] SRC_HOST = '0;

  typedef struct packed {
    logic             is_read;
    logic [SRC_W-1:0] src;
  } tag_t;
endpackage

// File: rtl/vram_bus_arbiter_rr_arbiter.sv
// Generic N-way round-robin picker: combinational grant, pointer registered on each grant.
// Search starts just above the last winner and wraps explicitly at N-1.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] pick;
  logic          found;

  // Two descending passes: indices above the pointer override those at or below it,
  // so the lowest index past the pointer wins, else the lowest index overall.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) <= rr_q)) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) > rr_q)) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    vld = found & en;
    idx = pick;
    gnt = '0;
    if (vld) gnt[pick] = 1'b1;
    rr_d = vld ? pick : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= IW'(N - 1);
    else        rr_q <= rr_d;
  end
endmodule

// File: rtl/vram_bus_arbiter.sv
// Shares the VRAM bus master between the host (absolute priority, no stall) and N clients (round-robin).
// Issue is registered (T+1); read data returns at T+2 and is steered by a 2-stage tag pipeline.
module vram_bus_arbiter
  import vram_bus_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int AW        = VRAM_AW,
  parameter int DW        = VRAM_DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           host_addr,
  input  logic [DW-1:0]           host_wrdata,
  input  logic                    host_strobe,
  input  logic                    host_write,
  output logic [DW-1:0]           host_rddata,
  output logic                    host_rdvalid,
  input  logic [N_CLIENTS-1:0]    cl_req,
  input  logic [N_CLIENTS*AW-1:0] cl_addr,
  input  logic [N_CLIENTS*DW-1:0] cl_wrdata,
  input  logic [N_CLIENTS-1:0]    cl_write,
  output logic [N_CLIENTS-1:0]    cl_ack,
  output logic [DW-1:0]           cl_rddata,
  output logic [N_CLIENTS-1:0]    cl_rdvalid,
  output logic [AW-1:0]           bm_addr,
  output logic [DW-1:0]           bm_wrdata,
  output logic                    bm_strobe,
  output logic                    bm_write,
  input  logic [DW-1:0]           bm_rddata
);
  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  logic [N_CLIENTS-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_vld;
  logic                 arb_en;

  logic [AW-1:0] bm_addr_q, bm_addr_d;
  logic [DW-1:0] bm_wrdata_q, bm_wrdata_d;
  logic          bm_strobe_q, bm_strobe_d;
  logic          bm_write_q, bm_write_d;
  tag_t          tag1_q, tag1_d, tag2_q, tag2_d;
  logic [DW-1:0] host_rd_q, host_rd_d;

  // Gating with rst_n keeps a held request from being acked while in reset.
  assign arb_en = ~host_strobe & rst_n;

  rr_arbiter #(.N(N_CLIENTS), .IW(IW)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (cl_req),
    .en    (arb_en),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .vld   (gnt_vld)
  );

  always_comb begin
    bm_strobe_d = 1'b0;
    bm_write_d  = 1'b0;
    bm_addr_d   = bm_addr_q;
    bm_wrdata_d = bm_wrdata_q;
    tag1_d      = '0;
    if (host_strobe) begin
      bm_strobe_d    = 1'b1;
      bm_write_d     = host_write;
      bm_addr_d      = host_addr;
      bm_wrdata_d    = host_wrdata;
      tag1_d.is_read = ~host_write;
      tag1_d.src     = SRC_HOST;
    end else if (gnt_vld) begin
      bm_strobe_d    = 1'b1;
      bm_write_d     = cl_write[gnt_idx];
      bm_addr_d      = cl_addr[int'(gnt_idx)*AW +: AW];
      bm_wrdata_d    = cl_wrdata[int'(gnt_idx)*DW +: DW];
      tag1_d.is_read = ~cl_write[gnt_idx];
      tag1_d.src     = SRC_W'(gnt_idx) + SRC_W'(1);
    end
    tag2_d = tag1_q;
  end

  always_comb begin
    host_rdvalid = tag2_q.is_read && (tag2_q.src == SRC_HOST);
    for (int i = 0; i < N_CLIENTS; i++) begin
      cl_rdvalid[i] = tag2_q.is_read && (tag2_q.src == SRC_W'(i + 1));
    end
    host_rd_d   = host_rdvalid ? bm_rddata : host_rd_q;
    host_rddata = host_rd_d;
    cl_rddata   = bm_rddata;
    cl_ack      = gnt;
    bm_addr     = bm_addr_q;
    bm_wrdata   = bm_wrdata_q;
    bm_strobe   = bm_strobe_q;
    bm_write    = bm_write_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bm_addr_q   <= '0;
      bm_wrdata_q <= '0;
      bm_strobe_q <= 1'b0;
      bm_write_q  <= 1'b0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      host_rd_q   <= '0;
    end else begin
      bm_addr_q   <= bm_addr_d;
      bm_wrdata_q <= bm_wrdata_d;
      bm_strobe_q <= bm_strobe_d;
      bm_write_q  <= bm_write_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      host_rd_q   <= host_rd_d;
    end
  end
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Bench for vram_bus_arbiter: grant table, directed corner sequences and a random soak
// against a queue-based reference with its own memory image.
module tb_vram_bus_arbiter;
  localparam int NC = 2;
  localparam int AW = 19;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    host_addr = '0;
  logic [DW-1:0]    host_wrdata = '0;
  logic             host_strobe = 1'b0;
  logic             host_write = 1'b0;
  logic [DW-1:0]    host_rddata;
  logic             host_rdvalid;
  logic [NC-1:0]    cl_req = '0;
  logic [NC*AW-1:0] cl_addr = '0;
  logic [NC*DW-1:0] cl_wrdata = '0;
  logic [NC-1:0]    cl_write = '0;
  logic [NC-1:0]    cl_ack;
  logic [DW-1:0]    cl_rddata;
  logic [NC-1:0]    cl_rdvalid;
  logic [AW-1:0]    bm_addr;
  logic [DW-1:0]    bm_wrdata;
  logic             bm_strobe;
  logic             bm_write;
  logic [DW-1:0]    bm_rddata;

  vram_bus_arbiter #(.N_CLIENTS(NC), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_addr(host_addr), .host_wrdata(host_wrdata), .host_strobe(host_strobe),
    .host_write(host_write), .host_rddata(host_rddata), .host_rdvalid(host_rdvalid),
    .cl_req(cl_req), .cl_addr(cl_addr), .cl_wrdata(cl_wrdata), .cl_write(cl_write),
    .cl_ack(cl_ack), .cl_rddata(cl_rddata), .cl_rdvalid(cl_rdvalid),
    .bm_addr(bm_addr), .bm_wrdata(bm_wrdata), .bm_strobe(bm_strobe),
    .bm_write(bm_write), .bm_rddata(bm_rddata)
  );

  always #5 clk = ~clk;

  // VRAM slave: read data appears in the cycle after the strobe.
  logic [DW-1:0] vram [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_q = '0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (bm_strobe) begin
      if (bm_write) vram[bm_addr] = bm_wrdata;
      else rd_q <= vram.exists(bm_addr) ? vram[bm_addr] : init_val(bm_addr);
    end
  end
  assign bm_rddata = rd_q;

  // Client protocol: a request not acked must still be present next cycle.
  logic [NC-1:0] prev_req = '0, prev_ack = '0;
  logic          prev_vld = 1'b0;
  always @(posedge clk) begin
    if (rst_n && prev_vld) begin
      for (int i = 0; i < NC; i++)
        assert (!(prev_req[i] && !prev_ack[i] && !cl_req[i])) else $error("client %0d dropped req", i);
    end
    prev_req <= cl_req;
    prev_ack <= cl_ack;
    prev_vld <= rst_n;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    host_strobe = 1'b0;
    host_write = 1'b0;
    cl_req = '0;
    cl_write = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          hs;
    logic [NC-1:0] req;
    logic [NC-1:0] ack;
    logic          stb;
    logic [AW-1:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic hs, input logic [1:0] req, input logic [1:0] ack,
                              input logic stb, input logic [AW-1:0] addr);
    vec_t v;
    v.hs = hs; v.req = req; v.ack = ack; v.stb = stb; v.addr = addr;
    return v;
  endfunction

  typedef struct {
    int            due;
    int            src;
    logic [DW-1:0] d;
  } rd_t;

  localparam logic [AW-1:0] HA = 19'h00AAA;
  localparam logic [AW-1:0] C0 = 19'h00100;
  localparam logic [AW-1:0] C1 = 19'h00200;

  vec_t vecs[14];
  rd_t  rq[$];

  initial begin
    int            rr_m;
    int            m_src;
    logic          hs_prev;
    logic [NC-1:0] m_ack, ack_seen, exp_cv;
    logic          exp_h;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] a;
    int            wait_cnt[NC];
    rd_t           e;

    vram[19'h12345] = 8'hA5;
    vram[19'h00010] = 8'h3C;

    vecs[0]  = mk(0, 2'b00, 2'b00, 0, '0);
    vecs[1]  = mk(1, 2'b01, 2'b00, 0, '0);
    vecs[2]  = mk(0, 2'b01, 2'b01, 1, HA);
    vecs[3]  = mk(0, 2'b11, 2'b10, 1, C0);
    vecs[4]  = mk(0, 2'b11, 2'b01, 1, C1);
    vecs[5]  = mk(0, 2'b11, 2'b10, 1, C0);
    vecs[6]  = mk(0, 2'b11, 2'b01, 1, C1);
    vecs[7]  = mk(1, 2'b11, 2'b00, 1, C0);
    vecs[8]  = mk(0, 2'b11, 2'b10, 1, HA);
    vecs[9]  = mk(0, 2'b01, 2'b01, 1, C1);
    vecs[10] = mk(0, 2'b10, 2'b10, 1, C0);
    vecs[11] = mk(0, 2'b10, 2'b10, 1, C1);
    vecs[12] = mk(0, 2'b00, 2'b00, 1, C1);
    vecs[13] = mk(0, 2'b00, 2'b00, 0, C1);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_bm_strobe", bm_strobe, 0);
    chk("rst_bm_write", bm_write, 0);
    chk("rst_bm_addr", bm_addr, 0);
    chk("rst_bm_wrdata", bm_wrdata, 0);
    chk("rst_host_rdvalid", host_rdvalid, 0);
    chk("rst_cl_rdvalid", cl_rdvalid, 0);
    chk("rst_host_rddata", host_rddata, 0);
    next_cycle();

    // Grant table: collision, round-robin, back-to-back issue
    host_addr = HA; host_write = 1'b1; host_wrdata = 8'h11;
    cl_addr = {C1, C0}; cl_write = 2'b11; cl_wrdata = {8'h22, 8'h33};
    for (int r = 0; r < 14; r++) begin
      host_strobe = vecs[r].hs;
      cl_req = vecs[r].req;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", r), cl_ack, vecs[r].ack);
      chk($sformatf("tbl%0d_strobe", r), bm_strobe, vecs[r].stb);
      if (vecs[r].stb) chk($sformatf("tbl%0d_addr", r), bm_addr, vecs[r].addr);
      next_cycle();
    end

    // Host read: fixed two-cycle return, then held value
    host_strobe = 1'b1; host_write = 1'b0; host_addr = 19'h12345;
    next_cycle();
    host_strobe = 1'b0;
    @(negedge clk);
    chk("hrd_strobe", bm_strobe, 1);
    chk("hrd_addr", bm_addr, 19'h12345);
    chk("hrd_write", bm_write, 0);
    chk("hrd_early_valid", host_rdvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("hrd_valid", host_rdvalid, 1);
    chk("hrd_data", host_rddata, 8'hA5);
    next_cycle();
    @(negedge clk);
    chk("hrd_valid_drop", host_rdvalid, 0);
    chk("hrd_data_hold", host_rddata, 8'hA5);
    next_cycle();

    // Client 1 read followed directly by a host write
    cl_req = 2'b10; cl_write = 2'b00; cl_addr = {19'h00010, C0};
    @(negedge clk);
    chk("mix_ack", cl_ack, 2'b10);
    next_cycle();
    cl_req = 2'b00;
    host_strobe = 1'b1; host_write = 1'b1; host_addr = 19'h00020; host_wrdata = 8'h77;
    @(negedge clk);
    chk("mix_cl_strobe", bm_strobe, 1);
    chk("mix_cl_addr", bm_addr, 19'h00010);
    next_cycle();
    host_strobe = 1'b0;
    @(negedge clk);
    chk("mix_cl_rdvalid", cl_rdvalid, 2'b10);
    chk("mix_cl_rddata", cl_rddata, 8'h3C);
    chk("mix_no_host_rdvalid", host_rdvalid, 0);
    chk("mix_host_write", bm_write, 1);
    chk("mix_host_wdata", bm_wrdata, 8'h77);
    next_cycle();
    @(negedge clk);
    chk("mix_cl_rdvalid_once", cl_rdvalid, 2'b00);
    chk("mix_host_rdvalid_none", host_rdvalid, 0);
    chk("mix_mem", vram.exists(19'h00020) ? vram[19'h00020] : 8'h00, 8'h77);
    next_cycle();

    // Reset while a client read is in flight
    cl_req = 2'b01; cl_write = 2'b00; cl_addr = {C1, 19'h00030};
    @(negedge clk);
    chk("rmf_ack", cl_ack, 2'b01);
    next_cycle();
    rst_n = 1'b0;
    cl_req = 2'b11; cl_write = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rmf_no_ack", cl_ack, 0);
      chk("rmf_strobe", bm_strobe, 0);
      chk("rmf_bus", {bm_write, bm_addr, bm_wrdata}, 0);
      chk("rmf_rdvalid", cl_rdvalid, 0);
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmf_first_grant", cl_ack, 2'b01);
    chk("rmf_rdvalid_after", cl_rdvalid, 0);
    next_cycle();
    cl_req = 2'b10;
    @(negedge clk);
    chk("rmf_rdvalid_late", cl_rdvalid, 0);
    next_cycle();

    // Random soak against the reference model
    do_reset();
    ref_mem = vram;
    rr_m = NC - 1;
    hs_prev = 1'b0;
    ack_seen = '0;
    for (int i = 0; i < NC; i++) wait_cnt[i] = 0;
    rq.delete();
    for (int c = 0; c < 10000; c++) begin
      host_strobe = !hs_prev && ($urandom % 3 == 0);
      hs_prev = host_strobe;
      host_write = 1'($urandom % 2);
      host_addr = AW'($urandom_range(0, 63));
      host_wrdata = DW'($urandom);
      for (int i = 0; i < NC; i++) begin
        if (ack_seen[i] || !cl_req[i]) begin
          cl_req[i] = 1'($urandom % 2);
          cl_write[i] = 1'($urandom % 2);
          cl_addr[i*AW +: AW] = AW'($urandom_range(0, 63));
          cl_wrdata[i*DW +: DW] = DW'($urandom);
        end
      end
      @(negedge clk);

      m_ack = '0;
      m_src = -1;
      if (host_strobe) m_src = 0;
      else begin
        for (int k = 1; k <= NC; k++) begin
          int j;
          j = (rr_m + k) % NC;
          if (cl_req[j]) begin
            m_ack[j] = 1'b1;
            m_src = j + 1;
            rr_m = j;
            break;
          end
        end
      end
      chk("soak_ack", cl_ack, m_ack);
      if (m_src == 0) begin
        if (host_write) ref_mem[host_addr] = host_wrdata;
        else begin
          e.due = c + 2; e.src = 0;
          e.d = ref_mem.exists(host_addr) ? ref_mem[host_addr] : init_val(host_addr);
          rq.push_back(e);
        end
      end else if (m_src > 0) begin
        a = cl_addr[(m_src-1)*AW +: AW];
        if (cl_write[m_src-1]) ref_mem[a] = cl_wrdata[(m_src-1)*DW +: DW];
        else begin
          e.due = c + 2; e.src = m_src;
          e.d = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
          rq.push_back(e);
        end
      end

      exp_h = 1'b0; exp_cv = '0; exp_d = '0;
      if (rq.size() > 0 && rq[0].due == c) begin
        e = rq.pop_front();
        if (e.src == 0) exp_h = 1'b1;
        else exp_cv[e.src-1] = 1'b1;
        exp_d = e.d;
      end
      chk("soak_host_rdvalid", host_rdvalid, exp_h);
      chk("soak_cl_rdvalid", cl_rdvalid, exp_cv);
      if (exp_h) chk("soak_host_rddata", host_rddata, exp_d);
      if (exp_cv != 0) chk("soak_cl_rddata", cl_rddata, exp_d);

      for (int i = 0; i < NC; i++) begin
        if (cl_req[i]) begin
          if (!host_strobe) wait_cnt[i]++;
          if (cl_ack[i]) begin
            chk($sformatf("soak_wait%0d", i), 32'(wait_cnt[i] <= NC), 1);
            wait_cnt[i] = 0;
          end
        end
      end
      ack_seen = cl_ack;
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
